// File: rtl/pitch_freq_module_if.sv
// Handshake bundle between the min-tau search stage and the pitch-frequency divider.
interface pitch_freq_module_if #(
  parameter int unsigned FREQ_WIDTH = 16,
  parameter int unsigned TAU_WIDTH  = 8
);
  logic                  tau_ready;
  logic [TAU_WIDTH-1:0]  min_tau;
  logic                  busy;
  logic [FREQ_WIDTH-1:0] freq;
  logic                  freq_valid;
  logic                  voiced;

  // Upstream side: presents the lag, consumes the pitch result.
  modport master (
    output tau_ready,
    output min_tau,
    input  busy,
    input  freq,
    input  freq_valid,
    input  voiced
  );

  // Divider side.
  modport slave (
    input  tau_ready,
    input  min_tau,
    output busy,
    output freq,
    output freq_valid,
    output voiced
  );
endinterface

// File: rtl/pitch_freq_module.sv
// Converts the lag of the first sub-threshold dip into a pitch estimate,
// freq = floor(SAMPLE_RATE / min_tau), using a bit-serial restoring divider.
module pitch_freq_module #(
  parameter int unsigned SAMPLE_RATE = 8000,
  parameter int unsigned FREQ_WIDTH  = 16,
  parameter int unsigned TAU_WIDTH   = 8,
  parameter int unsigned MIN_TAU     = 2
) (
  input logic                clk,
  input logic                reset,
  pitch_freq_module_if.slave bus
);

  localparam int unsigned CntWidth = (FREQ_WIDTH > 1) ? $clog2(FREQ_WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic                  tau_ready_q;
  logic [TAU_WIDTH-1:0]  tau_q, tau_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [TAU_WIDTH-1:0]  rem_q, rem_d;
  logic [FREQ_WIDTH-1:0] div_q, div_d;
  logic [FREQ_WIDTH-1:0] quot_q, quot_d;
  logic                  vnext_q, vnext_d;
  logic [FREQ_WIDTH-1:0] freq_q, freq_d;
  logic                  voiced_q, voiced_d;
  logic                  valid_q, valid_d;

  logic                  tau_rise;
  logic [TAU_WIDTH:0]    rem_shift;

  assign tau_rise = bus.tau_ready & ~tau_ready_q;
  // Partial remainder with the next dividend bit appended; one bit wider than tau.
  assign rem_shift = {rem_q, div_q[FREQ_WIDTH-1]};

  // Edge register tracks tau_ready every cycle, regardless of state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tau_ready_q <= 1'b0;
    end else begin
      tau_ready_q <= bus.tau_ready;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      tau_q    <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quot_q   <= '0;
      vnext_q  <= 1'b0;
      freq_q   <= '0;
      voiced_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tau_q    <= tau_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quot_q   <= quot_d;
      vnext_q  <= vnext_d;
      freq_q   <= freq_d;
      voiced_q <= voiced_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic: latch lag, divide MSB first, publish result for one cycle.
  always_comb begin
    state_d  = state_q;
    tau_d    = tau_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quot_d   = quot_q;
    vnext_d  = vnext_q;
    freq_d   = freq_q;
    voiced_d = voiced_q;
    valid_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Edges seen outside idle are simply lost; no queueing.
        if (tau_rise) begin
          tau_d = bus.min_tau;
          if (bus.min_tau < TAU_WIDTH'(MIN_TAU)) begin
            state_d = StDone;
            quot_d  = '0;
            vnext_d = 1'b0;
          end else begin
            state_d = StDivide;
            cnt_d   = CntWidth'(FREQ_WIDTH - 1);
            rem_d   = '0;
            div_d   = FREQ_WIDTH'(SAMPLE_RATE);
            vnext_d = 1'b1;
          end
        end
      end
      StDivide: begin
        div_d = {div_q[FREQ_WIDTH-2:0], 1'b0};
        if (rem_shift >= {1'b0, tau_q}) begin
          // Difference is below tau, so the low bits hold it exactly.
          rem_d  = rem_shift[TAU_WIDTH-1:0] - tau_q;
          quot_d = {quot_q[FREQ_WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift[TAU_WIDTH-1:0];
          quot_d = {quot_q[FREQ_WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        freq_d   = quot_q;
        voiced_d = vnext_q;
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.freq       = freq_q;
  assign bus.voiced     = voiced_q;
  assign bus.freq_valid = valid_q;

endmodule

// File: tb/tb_pitch_freq_module.sv
// Directed bench for pitch_freq_module: hand-computed quotients, latency, busy span,
// retrigger suppression, reset abort and dropped-edge behaviour.
module tb_pitch_freq_module;

  localparam int unsigned FreqWidth = 16;
  localparam int unsigned TauWidth  = 8;
  localparam int          LatVoiced = 17;
  localparam int          LatUnv    = 1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  pitch_freq_module_if #(.FREQ_WIDTH(FreqWidth), .TAU_WIDTH(TauWidth)) bus ();

  pitch_freq_module #(
    .SAMPLE_RATE(8000),
    .FREQ_WIDTH (FreqWidth),
    .TAU_WIDTH  (TauWidth),
    .MIN_TAU    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clock until freq_valid; tau_ready must already be high. Scrambles min_tau after
  // the first edge so a latched lag is what gets divided.
  task automatic wait_result(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    do begin
      tick();
      cycles++;
      if (bus.busy) busy_cycles++;
      if (cycles == 1) bus.min_tau = ~bus.min_tau;
    end while (!bus.freq_valid && cycles < 64);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] tau, input int exp_freq,
                           input int exp_voiced, input int exp_lat);
    int cyc;
    int bcyc;
    bus.tau_ready = 1'b0;
    tick();
    bus.min_tau   = tau;
    bus.tau_ready = 1'b1;
    wait_result(cyc, bcyc);
    check({tag, ".lat"}, 32'(cyc - 1), 32'(exp_lat));
    check({tag, ".busy"}, 32'(bcyc), 32'(exp_lat));
    check({tag, ".freq"}, 32'(bus.freq), 32'(exp_freq));
    check({tag, ".voiced"}, 32'(bus.voiced), 32'(exp_voiced));
    tick();
    check({tag, ".strobe_once"}, 32'(bus.freq_valid), 32'd0);
    check({tag, ".hold"}, 32'(bus.freq), 32'(exp_freq));
  endtask

  initial begin
    int cyc;
    int bcyc;
    int pulses;
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.tau_ready = 1'b0;
    bus.min_tau   = '0;
    tick();
    tick();
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.freq", 32'(bus.freq), 32'd0);
    check("rst.valid", 32'(bus.freq_valid), 32'd0);
    check("rst.voiced", 32'(bus.voiced), 32'd0);
    reset = 1'b0;
    tick();

    run_frame("tau40", 8'd40, 200, 1, LatVoiced);

    // Holding tau_ready high must not retrigger.
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.freq_valid) pulses++;
    end
    check("hold.pulses", 32'(pulses), 32'd0);
    check("hold.busy", 32'(bus.busy), 32'd0);

    run_frame("tau80", 8'd80, 100, 1, LatVoiced);
    run_frame("tau3", 8'd3, 2666, 1, LatVoiced);
    run_frame("tau255", 8'd255, 31, 1, LatVoiced);
    run_frame("tau0", 8'd0, 0, 0, LatUnv);
    run_frame("tau1", 8'd1, 0, 0, LatUnv);
    run_frame("tau2", 8'd2, 4000, 1, LatVoiced);

    // Reset in the middle of a division aborts it with no strobe.
    bus.tau_ready = 1'b0;
    tick();
    bus.min_tau   = 8'd40;
    bus.tau_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.freq", 32'(bus.freq), 32'd0);
    check("abort.voiced", 32'(bus.voiced), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.freq_valid) pulses++;
    end
    check("abort.pulses", 32'(pulses), 32'd0);
    bus.tau_ready = 1'b0;
    reset         = 1'b0;
    run_frame("tau50", 8'd50, 160, 1, LatVoiced);

    // A fresh edge mid-division with another lag is ignored.
    bus.tau_ready = 1'b0;
    tick();
    bus.min_tau   = 8'd40;
    bus.tau_ready = 1'b1;
    tick();
    cyc = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc++;
    end
    bus.tau_ready = 1'b0;
    tick();
    cyc++;
    bus.min_tau   = 8'd80;
    bus.tau_ready = 1'b1;
    while (!bus.freq_valid && cyc < 64) begin
      tick();
      cyc++;
    end
    check("drop.lat", 32'(cyc - 1), 32'(LatVoiced));
    check("drop.freq", 32'(bus.freq), 32'd200);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.freq_valid) pulses++;
    end
    check("drop.no_retrigger", 32'(pulses), 32'd0);

    // tau_ready already high at reset release counts as a rising edge.
    reset         = 1'b1;
    bus.tau_ready = 1'b1;
    bus.min_tau   = 8'd80;
    tick();
    reset = 1'b0;
    wait_result(cyc, bcyc);
    check("relhigh.lat", 32'(cyc - 1), 32'(LatVoiced));
    check("relhigh.freq", 32'(bus.freq), 32'd100);
    check("relhigh.voiced", 32'(bus.voiced), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pitch_freq_module.md
PITCH_FREQ_MODULE -- requirements
Module: pitch_freq_module

Interface
REQ-001 Parameter SAMPLE_RATE, default 8000: input sample rate in Hz, the dividend of the frequency division; SHALL be less than 2**FREQ_WIDTH.
REQ-002 Parameter FREQ_WIDTH, default 16: width of the freq output and number of divider iterations.
REQ-003 Parameter TAU_WIDTH, default 8: width of min_tau.
REQ-004 Parameter MIN_TAU, default 2: smallest lag treated as voiced.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 tau_ready  input  1  upstream min-tau search done; level signal, stays high until the upstream stage is reset.
REQ-008 min_tau  input  TAU_WIDTH  lag in samples of the first sub-threshold dip; 0 means none found.
REQ-009 busy  output  1  high while a result is being computed.
REQ-010 freq  output  FREQ_WIDTH  pitch estimate in Hz, integer.
REQ-011 freq_valid  output  1  one-cycle strobe; freq and voiced are new.
REQ-012 voiced  output  1  1 = freq is a valid pitch; 0 = unvoiced frame.

Function
REQ-013 The block SHALL register tau_ready every cycle and detect a rising edge as tau_ready=1 with previous value 0.
REQ-014 States SHALL be IDLE, DIVIDE and DONE.
REQ-015 In IDLE, a detected rising edge SHALL latch min_tau in the same cycle.
REQ-016 On that edge, if min_tau < MIN_TAU, the FSM SHALL go to DONE with quotient 0 and voiced_next 0.
REQ-017 Otherwise the FSM SHALL go to DIVIDE with:
- iteration counter = FREQ_WIDTH-1
- remainder = 0
- dividend shift register = SAMPLE_RATE
- voiced_next = 1
REQ-018 DIVIDE SHALL do one restoring-division step per cycle, MSB first:
- remainder (TAU_WIDTH+1 bits) = {remainder, dividend MSB}
- if remainder >= latched tau: subtract tau and shift 1 into the quotient; else shift 0
REQ-019 DIVIDE SHALL last exactly FREQ_WIDTH cycles, then go to DONE.
REQ-020 The quotient SHALL be floor(SAMPLE_RATE / tau), with no rounding.
REQ-021 DONE SHALL load freq and voiced, pulse freq_valid high for exactly one cycle, then return to IDLE.
REQ-022 Latency from the edge that samples the rising tau_ready to freq_valid high:
- voiced frame: FREQ_WIDTH+1 clock edges
- unvoiced frame: 1 clock edge
REQ-023 busy SHALL be high in DIVIDE and DONE, and low in IDLE.
REQ-024 A rising tau_ready edge while not in IDLE SHALL be dropped, not queued; the edge register still updates.
REQ-025 tau_ready held high SHALL NOT retrigger; a new result requires tau_ready to go low and then high again.
REQ-026 freq and voiced SHALL hold their last values between strobes.
REQ-027 min_tau changes after latching SHALL NOT affect the computation in progress.

Reset
REQ-028 Reset high SHALL force, asynchronously:
- state IDLE
- busy=0, freq_valid=0, freq=0, voiced=0
- tau_ready edge register=0, counter=0, quotient=0, remainder=0
REQ-029 Reset during DIVIDE or DONE SHALL abort the computation with no freq_valid strobe.
REQ-030 If tau_ready is already high when reset is released, the cleared edge register SHALL make that count as a rising edge on the first clock.

Verification
REQ-031 tau_ready 0->1 with min_tau=40 -> after 17 edges: freq=200, voiced=1, freq_valid high 1 cycle, busy high for 17 cycles.
REQ-032 min_tau=3 -> freq=2666 (truncated); min_tau=255 -> freq=31.
REQ-033 min_tau=0 and min_tau=1 -> after 1 edge: freq=0, voiced=0, freq_valid pulse, no DIVIDE cycles.
REQ-034 tau_ready held high 100 cycles after a result -> exactly one freq_valid pulse; toggle 0->1 with min_tau=80 -> second pulse with freq=100.
REQ-035 Reset asserted at DIVIDE cycle 8 -> all outputs 0 immediately, no freq_valid; after release with tau_ready low then rising and min_tau=50 -> freq=160.
REQ-036 Rising tau_ready edge injected during DIVIDE with a different min_tau -> ignored; result matches the original latched tau.
